// File: rtl/axi_bw_mon_pkg.sv
// Shared types and helpers for the multi-channel AXI bandwidth monitor.
package axi_bw_mon_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bw_state_e;

    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned BYTES_PER_BEAT = DEF_DATA_W / 8;
    localparam int unsigned STRB_MAX       = 128;
    localparam int unsigned SAT_W          = 64;

    function automatic logic [7:0] popcount(input logic [STRB_MAX-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < STRB_MAX; i++) begin
            cnt = cnt + 8'(v[i]);
        end
        return cnt;
    endfunction

    // Add clamped to the largest value representable in cnt_w bits.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      cnt_w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << cnt_w) - (SAT_W+1)'(1);
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end else begin
            return sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/axi_bw_mon_chan.sv
// Per-channel byte accumulators, window snapshots, peaks and sticky saturation.
module axi_bw_mon_chan
    import axi_bw_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned ADD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             discard_i,
    input  logic             count_i,
    input  logic             term_i,
    input  logic [ADD_W-1:0] rd_add_i,
    input  logic [ADD_W-1:0] wr_add_i,
    output logic [CNT_W-1:0] rd_snap_o,
    output logic [CNT_W-1:0] wr_snap_o,
    output logic [CNT_W-1:0] rd_peak_o,
    output logic [CNT_W-1:0] wr_peak_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] rd_acc_q, rd_acc_d, wr_acc_q, wr_acc_d;
    logic [CNT_W-1:0] rd_snap_q, rd_snap_d, wr_snap_q, wr_snap_d;
    logic [CNT_W-1:0] rd_peak_q, rd_peak_d, wr_peak_q, wr_peak_d;
    logic             sat_q, sat_d;
    logic [CNT_W:0]   rd_raw_s, wr_raw_s;
    logic [CNT_W-1:0] rd_sum_s, wr_sum_s;

    assign rd_raw_s = {1'b0, rd_acc_q} + (CNT_W+1)'(rd_add_i);
    assign wr_raw_s = {1'b0, wr_acc_q} + (CNT_W+1)'(wr_add_i);
    assign rd_sum_s = CNT_W'(sat_add(SAT_W'(rd_acc_q), SAT_W'(rd_add_i), CNT_W));
    assign wr_sum_s = CNT_W'(sat_add(SAT_W'(wr_acc_q), SAT_W'(wr_add_i), CNT_W));

    // Next-state: clear beats discard beats terminal snapshot beats accumulate.
    always_comb begin
        rd_acc_d  = rd_acc_q;
        wr_acc_d  = wr_acc_q;
        rd_snap_d = rd_snap_q;
        wr_snap_d = wr_snap_q;
        rd_peak_d = rd_peak_q;
        wr_peak_d = wr_peak_q;
        sat_d     = sat_q;
        if (clr_i) begin
            rd_acc_d  = '0;
            wr_acc_d  = '0;
            rd_snap_d = '0;
            wr_snap_d = '0;
            rd_peak_d = '0;
            wr_peak_d = '0;
            sat_d     = 1'b0;
        end else if (discard_i) begin
            rd_acc_d = '0;
            wr_acc_d = '0;
        end else if (count_i) begin
            sat_d = sat_q | rd_raw_s[CNT_W] | wr_raw_s[CNT_W];
            if (term_i) begin
                rd_acc_d  = '0;
                wr_acc_d  = '0;
                rd_snap_d = rd_sum_s;
                wr_snap_d = wr_sum_s;
                rd_peak_d = (rd_sum_s > rd_peak_q) ? rd_sum_s : rd_peak_q;
                wr_peak_d = (wr_sum_s > wr_peak_q) ? wr_sum_s : wr_peak_q;
            end else begin
                rd_acc_d = rd_sum_s;
                wr_acc_d = wr_sum_s;
            end
        end else begin
            sat_d = sat_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_acc_q  <= '0;
            wr_acc_q  <= '0;
            rd_snap_q <= '0;
            wr_snap_q <= '0;
            rd_peak_q <= '0;
            wr_peak_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            rd_acc_q  <= rd_acc_d;
            wr_acc_q  <= wr_acc_d;
            rd_snap_q <= rd_snap_d;
            wr_snap_q <= wr_snap_d;
            rd_peak_q <= rd_peak_d;
            wr_peak_q <= wr_peak_d;
            sat_q     <= sat_d;
        end
    end

    assign rd_snap_o = rd_snap_q;
    assign wr_snap_o = wr_snap_q;
    assign rd_peak_o = rd_peak_q;
    assign wr_peak_o = wr_peak_q;
    assign sat_o     = sat_q;

endmodule

// File: rtl/axi_bw_mon.sv
// Multi-channel AXI bandwidth monitor: window timer/FSM, per-channel counters, report mux.
module axi_bw_mon
    import axi_bw_mon_pkg::*;
#(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WIN_W      = 24,
    parameter int unsigned WSTRB_MODE = 1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_en,
    input  logic                       cfg_clr,
    input  logic [WIN_W-1:0]           cfg_win_cycles,
    input  logic [NUM_CH-1:0]          ch_rvalid,
    input  logic [NUM_CH-1:0]          ch_rready,
    input  logic [NUM_CH-1:0]          ch_wvalid,
    input  logic [NUM_CH-1:0]          ch_wready,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
    input  logic [$clog2(NUM_CH)-1:0]  rpt_sel,
    output logic [CNT_W-1:0]           rpt_rd_bytes,
    output logic [CNT_W-1:0]           rpt_wr_bytes,
    output logic [CNT_W-1:0]           rpt_rd_peak,
    output logic [CNT_W-1:0]           rpt_wr_peak,
    output logic                       win_done,
    output logic [15:0]                win_idx,
    output logic [NUM_CH-1:0]          sat_flag
);

    localparam int unsigned BPB   = DATA_W / 8;
    localparam int unsigned ADD_W = $clog2(BPB + 1);
    localparam int unsigned SEL_W = $clog2(NUM_CH);

    bw_state_e        state_q;
    logic [WIN_W-1:0] timer_q;
    logic [15:0]      win_idx_q;
    logic             win_done_q;
    logic             run_s, discard_s, count_s, term_s;

    logic [CNT_W-1:0] rd_snap_s [NUM_CH];
    logic [CNT_W-1:0] wr_snap_s [NUM_CH];
    logic [CNT_W-1:0] rd_peak_s [NUM_CH];
    logic [CNT_W-1:0] wr_peak_s [NUM_CH];

    assign run_s     = (state_q == RUN);
    assign discard_s = run_s & ~cfg_en & ~cfg_clr;
    assign count_s   = run_s & cfg_en & ~cfg_clr;
    assign term_s    = count_s & (timer_q == '0);

    // Window FSM: timer counts down to 0 and reloads N-1 so windows are back-to-back.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            win_idx_q  <= 16'd0;
            win_done_q <= 1'b0;
        end else if (cfg_clr) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            win_idx_q  <= 16'd0;
            win_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    win_done_q <= 1'b0;
                    if (cfg_en && (cfg_win_cycles != '0)) begin
                        state_q <= RUN;
                        timer_q <= cfg_win_cycles - WIN_W'(1);
                    end
                end
                RUN: begin
                    if (!cfg_en) begin
                        state_q    <= IDLE;
                        win_done_q <= 1'b0;
                    end else if (timer_q == '0) begin
                        timer_q    <= cfg_win_cycles - WIN_W'(1);
                        win_idx_q  <= win_idx_q + 16'd1;
                        win_done_q <= 1'b1;
                        state_q    <= (cfg_win_cycles == '0) ? IDLE : RUN;
                    end else begin
                        timer_q    <= timer_q - WIN_W'(1);
                        win_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    win_done_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ADD_W-1:0] rd_add_s, wr_add_s;
        logic [ADD_W-1:0] strb_cnt_s;

        assign strb_cnt_s = (WSTRB_MODE != 0)
                          ? ADD_W'(popcount(STRB_MAX'(ch_wstrb[g*BPB +: BPB])))
                          : ADD_W'(BPB);
        assign rd_add_s = (ch_rvalid[g] & ch_rready[g]) ? ADD_W'(BPB) : '0;
        assign wr_add_s = (ch_wvalid[g] & ch_wready[g]) ? strb_cnt_s : '0;

        axi_bw_mon_chan #(
            .CNT_W (CNT_W),
            .ADD_W (ADD_W)
        ) u_chan (
            .clk       (aclk),
            .rst_n     (aresetn),
            .clr_i     (cfg_clr),
            .discard_i (discard_s),
            .count_i   (count_s),
            .term_i    (term_s),
            .rd_add_i  (rd_add_s),
            .wr_add_i  (wr_add_s),
            .rd_snap_o (rd_snap_s[g]),
            .wr_snap_o (wr_snap_s[g]),
            .rd_peak_o (rd_peak_s[g]),
            .wr_peak_o (wr_peak_s[g]),
            .sat_o     (sat_flag[g])
        );
    end

    // Report mux; an out-of-range select matches no channel and reads 0.
    always_comb begin
        rpt_rd_bytes = '0;
        rpt_wr_bytes = '0;
        rpt_rd_peak  = '0;
        rpt_wr_peak  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rpt_rd_bytes = (rpt_sel == SEL_W'(i)) ? rd_snap_s[i] : rpt_rd_bytes;
            rpt_wr_bytes = (rpt_sel == SEL_W'(i)) ? wr_snap_s[i] : rpt_wr_bytes;
            rpt_rd_peak  = (rpt_sel == SEL_W'(i)) ? rd_peak_s[i] : rpt_rd_peak;
            rpt_wr_peak  = (rpt_sel == SEL_W'(i)) ? wr_peak_s[i] : rpt_wr_peak;
        end
    end

    assign win_done = win_done_q;
    assign win_idx  = win_idx_q;

endmodule

// File: tb/tb_axi_bw_mon.sv
// Randomized and directed checks of axi_bw_mon against a window-level byte-count model.
module tb_axi_bw_mon;
    import axi_bw_mon_pkg::*;

    localparam int NC   = 5;
    localparam int CW   = 12;
    localparam int BPB  = BYTES_PER_BEAT;
    localparam longint MAXV = (64'd1 << CW) - 64'd1;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cfg_en, cfg_clr;
    logic [23:0]     cfg_win_cycles;
    logic [NC-1:0]   ch_rvalid, ch_rready, ch_wvalid, ch_wready;
    logic [NC*8-1:0] ch_wstrb;
    logic [2:0]      rpt_sel;
    logic [CW-1:0]   rpt_rd_bytes, rpt_wr_bytes, rpt_rd_peak, rpt_wr_peak;
    logic            win_done;
    logic [15:0]     win_idx;
    logic [NC-1:0]   sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit     m_run, m_done;
    int     m_left;
    longint m_acc_rd[NC], m_acc_wr[NC], m_snap_rd[NC], m_snap_wr[NC];
    longint m_pk_rd[NC], m_pk_wr[NC];
    bit     m_sat[NC];
    int     m_widx;

    axi_bw_mon #(.NUM_CH(NC), .DATA_W(64), .CNT_W(CW), .WIN_W(24), .WSTRB_MODE(1)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_en(cfg_en), .cfg_clr(cfg_clr),
        .cfg_win_cycles(cfg_win_cycles), .ch_rvalid(ch_rvalid), .ch_rready(ch_rready),
        .ch_wvalid(ch_wvalid), .ch_wready(ch_wready), .ch_wstrb(ch_wstrb), .rpt_sel(rpt_sel),
        .rpt_rd_bytes(rpt_rd_bytes), .rpt_wr_bytes(rpt_wr_bytes), .rpt_rd_peak(rpt_rd_peak),
        .rpt_wr_peak(rpt_wr_peak), .win_done(win_done), .win_idx(win_idx), .sat_flag(sat_flag)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void mdl_clear();
        m_run = 0; m_done = 0; m_left = 0; m_widx = 0;
        for (int c = 0; c < NC; c++) begin
            m_acc_rd[c] = 0; m_acc_wr[c] = 0; m_snap_rd[c] = 0; m_snap_wr[c] = 0;
            m_pk_rd[c] = 0; m_pk_wr[c] = 0; m_sat[c] = 0;
        end
    endfunction

    // One clock edge of the model: windows of N counted cycles, saturating sums.
    function automatic void mdl_step();
        longint nr, nw;
        m_done = 0;
        if (!aresetn || cfg_clr) begin
            mdl_clear();
            return;
        end
        if (!m_run) begin
            if (cfg_en && cfg_win_cycles != 0) begin
                m_run = 1; m_left = int'(cfg_win_cycles);
                for (int c = 0; c < NC; c++) begin m_acc_rd[c] = 0; m_acc_wr[c] = 0; end
            end
            return;
        end
        if (!cfg_en) begin
            m_run = 0;
            for (int c = 0; c < NC; c++) begin m_acc_rd[c] = 0; m_acc_wr[c] = 0; end
            return;
        end
        m_left--;
        for (int c = 0; c < NC; c++) begin
            nr = m_acc_rd[c] + ((ch_rvalid[c] && ch_rready[c]) ? BPB : 0);
            nw = m_acc_wr[c] + ((ch_wvalid[c] && ch_wready[c]) ? $countones(ch_wstrb[c*8 +: 8]) : 0);
            if (nr > MAXV) begin m_sat[c] = 1; nr = MAXV; end
            if (nw > MAXV) begin m_sat[c] = 1; nw = MAXV; end
            if (m_left == 0) begin
                m_snap_rd[c] = nr; m_snap_wr[c] = nw;
                if (nr > m_pk_rd[c]) m_pk_rd[c] = nr;
                if (nw > m_pk_wr[c]) m_pk_wr[c] = nw;
                m_acc_rd[c] = 0; m_acc_wr[c] = 0;
            end else begin
                m_acc_rd[c] = nr; m_acc_wr[c] = nw;
            end
        end
        if (m_left == 0) begin
            m_widx = (m_widx + 1) % 65536;
            m_done = 1;
            if (cfg_win_cycles == 0) m_run = 0;
            else m_left = int'(cfg_win_cycles);
        end
    endfunction

    task automatic compare();
        logic [NC-1:0] sat_e;
        for (int c = 0; c < NC; c++) sat_e[c] = m_sat[c];
        chk("win_done", win_done, m_done);
        chk("win_idx", win_idx, m_widx);
        chk("sat_flag", sat_flag, sat_e);
        if (rpt_sel < NC) begin
            chk("rpt_rd_bytes", rpt_rd_bytes, m_snap_rd[rpt_sel]);
            chk("rpt_wr_bytes", rpt_wr_bytes, m_snap_wr[rpt_sel]);
            chk("rpt_rd_peak", rpt_rd_peak, m_pk_rd[rpt_sel]);
            chk("rpt_wr_peak", rpt_wr_peak, m_pk_wr[rpt_sel]);
        end else begin
            chk("rpt_rd_bytes_oor", rpt_rd_bytes, 0);
            chk("rpt_wr_bytes_oor", rpt_wr_bytes, 0);
            chk("rpt_rd_peak_oor", rpt_rd_peak, 0);
            chk("rpt_wr_peak_oor", rpt_wr_peak, 0);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        mdl_step();
        #1;
        compare();
    endtask

    task automatic traffic_off();
        ch_rvalid = '0; ch_rready = '0; ch_wvalid = '0; ch_wready = '0; ch_wstrb = '0;
    endtask

    task automatic do_clear();
        cfg_clr = 1'b1;
        cycle();
        cfg_clr = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0; cfg_win_cycles = 24'd100;
        rpt_sel = 3'd0;
        traffic_off();
        mdl_clear();
        repeat (2) cycle();
        aresetn = 1'b1;

        // Continuous ch0 reads, 100-cycle windows
        cfg_en = 1'b1;
        do_clear();
        cycle();
        ch_rvalid = 5'b00001; ch_rready = 5'b00001;
        repeat (300) cycle();
        chk("t1_rd", rpt_rd_bytes, 64'd800);
        chk("t1_peak", rpt_rd_peak, 64'd800);
        chk("t1_idx", win_idx, 64'd3);
        chk("t1_done", win_done, 64'd1);

        // ch2 writes with wstrb 0x0F for half a window
        traffic_off();
        do_clear();
        rpt_sel = 3'd2;
        cycle();
        ch_wvalid[2] = 1'b1; ch_wready[2] = 1'b1; ch_wstrb[16 +: 8] = 8'h0F;
        repeat (50) cycle();
        traffic_off();
        repeat (50) cycle();
        chk("t2_wr", rpt_wr_bytes, 64'd200);
        chk("t2_rd", rpt_rd_bytes, 64'd0);
        chk("t2_done", win_done, 64'd1);
        rpt_sel = 3'd0;
        #1;
        chk("t2_ch0_wr", rpt_wr_bytes, 64'd0);

        // Beats on the terminal cycle and the one after; then clear on a terminal cycle
        do_clear();
        cfg_win_cycles = 24'd10; rpt_sel = 3'd3;
        cycle();
        for (int k = 1; k <= 40; k++) begin
            traffic_off();
            if (k == 10 || k == 11) begin ch_rvalid[3] = 1'b1; ch_rready[3] = 1'b1; end
            cfg_clr = (k == 40);
            cycle();
            if (k == 10) chk("t4_win1", rpt_rd_bytes, 64'd8);
            if (k == 20) chk("t4_win2", rpt_rd_bytes, 64'd8);
            if (k == 30) chk("t4_win3", rpt_rd_bytes, 64'd0);
            if (k == 40) begin
                chk("t5_clr_done", win_done, 64'd0);
                chk("t5_clr_idx", win_idx, 64'd0);
                chk("t5_clr_peak", rpt_rd_peak, 64'd0);
            end
        end
        cfg_clr = 1'b0;

        // cfg_en dropped mid-window, then a fresh full window
        cfg_win_cycles = 24'd100; rpt_sel = 3'd0;
        cycle();
        ch_rvalid = 5'b00001; ch_rready = 5'b00001;
        repeat (150) cycle();
        cfg_en = 1'b0;
        cycle();
        chk("t5_drop_done", win_done, 64'd0);
        chk("t5_drop_keep", rpt_rd_bytes, 64'd800);
        cfg_en = 1'b1;
        repeat (100) cycle();
        chk("t5_early", win_done, 64'd0);
        cycle();
        chk("t5_fresh", win_done, 64'd1);
        chk("t5_idx", win_idx, 64'd2);

        // Saturation on ch1
        traffic_off();
        do_clear();
        cfg_win_cycles = 24'd600; rpt_sel = 3'd1;
        cycle();
        ch_rvalid = 5'b00010; ch_rready = 5'b00010;
        repeat (600) cycle();
        chk("t3_sat_val", rpt_rd_bytes, MAXV);
        chk("t3_sat_flag", sat_flag, 64'd2);
        traffic_off();
        do_clear();
        chk("t3_sat_clr", sat_flag, 64'd0);

        // Randomized traffic and config
        cfg_win_cycles = 24'd7;
        for (int n = 0; n < 2500; n++) begin
            ch_rvalid = NC'($urandom); ch_rready = NC'($urandom);
            ch_wvalid = NC'($urandom); ch_wready = NC'($urandom);
            ch_wstrb  = {$urandom, $urandom};
            cfg_en    = ($urandom_range(0, 99) != 0);
            cfg_clr   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) cfg_win_cycles = 24'($urandom_range(0, 20));
            rpt_sel = 3'($urandom_range(0, 7));
            cycle();
        end
        cfg_clr = 1'b0; cfg_en = 1'b1;

        // Asynchronous reset mid-window, then first window after release
        cfg_win_cycles = 24'd50;
        repeat (20) cycle();
        #2;
        aresetn = 1'b0;
        mdl_clear();
        #1;
        compare();
        repeat (2) cycle();
        traffic_off();
        ch_rvalid = 5'b00001; ch_rready = 5'b00001;
        cfg_win_cycles = 24'd7; rpt_sel = 3'd0;
        aresetn = 1'b1;
        repeat (7) cycle();
        chk("t6_early", win_done, 64'd0);
        cycle();
        chk("t6_done", win_done, 64'd1);
        chk("t6_rd", rpt_rd_bytes, 64'd56);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
